// File: rtl/gauss_window_gen.sv
// gauss_window_gen: raster-stream 3x3 window generator. Two line buffers plus padding
// bubbles give exactly one masked window (and its corner code) per image pixel.
module gauss_window_gen #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IMG_WIDTH  = 64,
    parameter int unsigned IMG_HEIGHT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_pix,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] line0_data0,
    output logic [DATA_WIDTH-1:0] line0_data1,
    output logic [DATA_WIDTH-1:0] line0_data2,
    output logic [DATA_WIDTH-1:0] line1_data0,
    output logic [DATA_WIDTH-1:0] line1_data1,
    output logic [DATA_WIDTH-1:0] line1_data2,
    output logic [DATA_WIDTH-1:0] line2_data0,
    output logic [DATA_WIDTH-1:0] line2_data1,
    output logic [DATA_WIDTH-1:0] line2_data2,
    output logic [3:0]            corner_type,
    output logic                  win_valid,
    output logic                  frame_done
);
    localparam int unsigned CW = $clog2(IMG_WIDTH + 1);
    localparam int unsigned RW = $clog2(IMG_HEIGHT + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_PAD  = CW'(IMG_WIDTH);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_PAD  = RW'(IMG_HEIGHT);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    typedef enum logic [1:0] {IDLE, RUN, PADC, PADR} state_e;
    typedef logic [DATA_WIDTH-1:0] pix_t;

    state_e        state_q, state_d;
    logic [CW-1:0] vc_q, vc_d;
    logic [RW-1:0] vr_q, vr_d;

    pix_t lb0_q [0:IMG_WIDTH];
    pix_t lb1_q [0:IMG_WIDTH];
    pix_t new_col [0:2];
    pix_t col1_q [0:2];
    pix_t col1_d [0:2];
    pix_t col2_q [0:2];
    pix_t col2_d [0:2];
    pix_t tap_q [0:2][0:2];
    pix_t tap_d [0:2][0:2];

    logic [3:0] corner_q, corner_d;
    logic       win_valid_q, win_valid_d;
    logic       frame_done_q, frame_done_d;
    logic       advance, emit;
    logic       top_edge, bot_edge, left_edge, right_edge;
    pix_t       slot_pix;

    assign in_ready = !rst && (state_q == IDLE || state_q == RUN);

    always_comb begin
        slot_pix = '0;
        advance  = 1'b0;
        if (state_q == IDLE || state_q == RUN) begin
            advance  = in_valid && in_ready;
            slot_pix = in_pix;
        end else begin
            advance  = !rst;
        end

        // Column entering the window: current slot (row vr), then rows vr-1, vr-2
        new_col[0] = slot_pix;
        new_col[1] = lb1_q[vc_q];
        new_col[2] = lb0_q[vc_q];

        top_edge   = (vr_q == ROW_ONE);
        bot_edge   = (vr_q == ROW_PAD);
        left_edge  = (vc_q == COL_ONE);
        right_edge = (vc_q == COL_PAD);
        emit       = advance && (vr_q != '0) && (vc_q != '0);

        state_d      = state_q;
        vc_d         = vc_q;
        vr_d         = vr_q;
        col1_d       = col1_q;
        col2_d       = col2_q;
        tap_d        = tap_q;
        corner_d     = 4'd0;
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;

        if (advance) begin
            col1_d = new_col;
            col2_d = col1_q;
            case (state_q)
                IDLE, RUN: begin
                    state_d = (vc_q == COL_LAST) ? PADC : RUN;
                    vc_d    = vc_q + 1'b1;
                end
                PADC: begin
                    vc_d    = '0;
                    vr_d    = vr_q + 1'b1;
                    state_d = (vr_q == ROW_LAST) ? PADR : RUN;
                end
                PADR: begin
                    if (vc_q == COL_PAD) begin
                        state_d      = IDLE;
                        vc_d         = '0;
                        vr_d         = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        vc_d = vc_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (emit) begin
            // Out-of-image taps come from position, never from buffer contents
            tap_d[0][0] = (bot_edge || right_edge) ? '0 : new_col[0];
            tap_d[0][1] = bot_edge ? '0 : col1_q[0];
            tap_d[0][2] = (bot_edge || left_edge) ? '0 : col2_q[0];
            tap_d[1][0] = right_edge ? '0 : new_col[1];
            tap_d[1][1] = col1_q[1];
            tap_d[1][2] = left_edge ? '0 : col2_q[1];
            tap_d[2][0] = (top_edge || right_edge) ? '0 : new_col[2];
            tap_d[2][1] = top_edge ? '0 : col1_q[2];
            tap_d[2][2] = (top_edge || left_edge) ? '0 : col2_q[2];

            if (top_edge)
                corner_d = left_edge ? 4'd1 : (right_edge ? 4'd2 : 4'd8);
            else if (bot_edge)
                corner_d = left_edge ? 4'd5 : (right_edge ? 4'd6 : 4'd8);
            else
                corner_d = left_edge ? 4'd3 : (right_edge ? 4'd4 : 4'd8);
            win_valid_d = 1'b1;
        end
    end

    // Line buffers are deliberately not reset; edge masking hides stale contents.
    always_ff @(posedge clk) begin
        if (advance && !rst) begin
            lb1_q[vc_q] <= slot_pix;
            lb0_q[vc_q] <= lb1_q[vc_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            vc_q         <= '0;
            vr_q         <= '0;
            col1_q       <= '{default: '0};
            col2_q       <= '{default: '0};
            tap_q        <= '{default: '{default: '0}};
            corner_q     <= 4'd0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vc_q         <= vc_d;
            vr_q         <= vr_d;
            col1_q       <= col1_d;
            col2_q       <= col2_d;
            tap_q        <= tap_d;
            corner_q     <= corner_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign line0_data0 = tap_q[0][0];
    assign line0_data1 = tap_q[0][1];
    assign line0_data2 = tap_q[0][2];
    assign line1_data0 = tap_q[1][0];
    assign line1_data1 = tap_q[1][1];
    assign line1_data2 = tap_q[1][2];
    assign line2_data0 = tap_q[2][0];
    assign line2_data1 = tap_q[2][1];
    assign line2_data2 = tap_q[2][2];
    assign corner_type = corner_q;
    assign win_valid   = win_valid_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_gauss_window_gen.sv
// Self-checking bench for gauss_window_gen: directed 4x3 frames on one instance and a
// full default-size 64x64 frame on a second instance.
`timescale 1ns/1ps
module tb_gauss_window_gen;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int BW = 64;
    localparam int BH = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] in_pix;
    logic       in_valid, in_ready;
    logic [7:0] t [9];
    logic [3:0] corner_type;
    logic       win_valid, frame_done;

    logic [7:0] b_pix;
    logic       b_valid, b_ready;
    logic [7:0] bt [9];
    logic [3:0] b_ct;
    logic       b_win, b_done;

    gauss_window_gen #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .in_pix(in_pix), .in_valid(in_valid), .in_ready(in_ready),
        .line0_data0(t[0]), .line0_data1(t[1]), .line0_data2(t[2]),
        .line1_data0(t[3]), .line1_data1(t[4]), .line1_data2(t[5]),
        .line2_data0(t[6]), .line2_data1(t[7]), .line2_data2(t[8]),
        .corner_type(corner_type), .win_valid(win_valid), .frame_done(frame_done)
    );

    gauss_window_gen #(.DATA_WIDTH(8), .IMG_WIDTH(BW), .IMG_HEIGHT(BH)) dut_big (
        .clk(clk), .rst(rst), .in_pix(b_pix), .in_valid(b_valid), .in_ready(b_ready),
        .line0_data0(bt[0]), .line0_data1(bt[1]), .line0_data2(bt[2]),
        .line1_data0(bt[3]), .line1_data1(bt[4]), .line1_data2(bt[5]),
        .line2_data0(bt[6]), .line2_data1(bt[7]), .line2_data2(bt[8]),
        .corner_type(b_ct), .win_valid(b_win), .frame_done(b_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pix_val(input int kind, input int base, input int r,
                                           input int c, input int w);
        return (kind == 0) ? 8'(base) : 8'(base + r * w + c);
    endfunction

    function automatic logic [71:0] exp_win(input int kind, input int base, input int idx,
                                            input int w, input int h);
        logic [71:0] v;
        int r, c, rr, cc;
        v = '0;
        r = idx / w;
        c = idx % w;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 3; j++) begin
                rr = r + 1 - k;
                cc = c + 1 - j;
                if (rr >= 0 && rr < h && cc >= 0 && cc < w)
                    v[71 - 8 * (k * 3 + j) -: 8] = pix_val(kind, base, rr, cc, w);
            end
        end
        return v;
    endfunction

    int ct_exp [12] = '{1, 8, 8, 2, 3, 8, 8, 4, 5, 8, 8, 6};

    logic [71:0] win_q [$];
    logic [3:0]  ct_q [$];
    int fd_cnt, fd_idx, stall_viol, rdy_low, acc_at_done;
    logic prev_stall = 1'b0;

    always @(negedge clk) begin
        #2;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (win_valid) begin
                win_q.push_back({t[0], t[1], t[2], t[3], t[4], t[5], t[6], t[7], t[8]});
                ct_q.push_back(corner_type);
                if (prev_stall) stall_viol++;
            end
            if (frame_done) begin
                fd_cnt++;
                fd_idx = win_q.size();
                if (in_valid && in_ready) acc_at_done++;
            end
            if (!in_ready) rdy_low++;
            prev_stall = in_ready && !in_valid;
        end
    end

    int b_cnt = 0, b_err = 0, b_c8 = 0, b_c3 = 0, b_fd = 0;

    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (b_win) begin
                if ({bt[0], bt[1], bt[2], bt[3], bt[4], bt[5], bt[6], bt[7], bt[8]}
                    !== exp_win(0, 255, b_cnt, BW, BH)) b_err++;
                if (b_ct == 4'd8) b_c8++;
                if (b_ct == 4'd3) b_c3++;
                b_cnt++;
            end
            if (b_done) b_fd++;
        end
    end

    task automatic clear_stats();
        win_q.delete();
        ct_q.delete();
        fd_cnt = 0; fd_idx = 0; stall_viol = 0; rdy_low = 0; acc_at_done = 0;
    endtask

    task automatic drive_frame(input int kind, input int base, input bit stalls, input int npix);
        int idx = 0;
        int cyc = 0;
        while (idx < npix && cyc < 1000) begin
            @(negedge clk);
            in_valid = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
            in_pix   = pix_val(kind, base, idx / W, idx % W, W);
            #1;
            if (in_valid && in_ready) idx++;
            cyc++;
        end
        check("drive_accepted", 72'(idx), 72'(npix));
    endtask

    task automatic wait_windows(input int n, input string tag);
        int cyc = 0;
        while (win_q.size() < n && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        check({tag, "_count"}, 72'(win_q.size()), 72'(n));
    endtask

    task automatic check_frame(input int kind, input int base, input int off, input string tag);
        for (int i = 0; i < W * H; i++) begin
            check($sformatf("%s_win%0d", tag, i), win_q[off + i], exp_win(kind, base, i, W, H));
            check($sformatf("%s_ct%0d", tag, i), 72'(ct_q[off + i]), 72'(ct_exp[i]));
        end
    endtask

    initial begin
        int acc, cyc;
        rst = 1'b1; in_valid = 1'b0; in_pix = '0;
        b_valid = 1'b0; b_pix = 8'd255;
        clear_stats();
        repeat (3) @(negedge clk);
        #2;
        check("rst_in_ready", 72'(in_ready), 72'(0));
        check("rst_win_valid", 72'(win_valid), 72'(0));
        check("rst_frame_done", 72'(frame_done), 72'(0));
        check("rst_corner", 72'(corner_type), 72'(0));
        check("rst_taps", {t[0], t[1], t[2], t[3], t[4], t[5], t[6], t[7], t[8]}, 72'(0));
        @(negedge clk) rst = 1'b0;
        #2 check("idle_in_ready", 72'(in_ready), 72'(1));

        // Flat frame, no stalls
        clear_stats();
        drive_frame(0, 16, 1'b0, 12);
        @(negedge clk) in_valid = 1'b0;
        wait_windows(12, "flat");
        check_frame(0, 16, 0, "flat");
        check("flat_c11", win_q[5], 72'h101010_101010_101010);
        check("flat_c01", win_q[1], 72'h101010_101010_000000);
        check("flat_fd_cnt", 72'(fd_cnt), 72'(1));
        check("flat_fd_pos", 72'(fd_idx), 72'(12));
        check("flat_rdy_low", 72'(rdy_low), 72'(H + W + 1));

        // Ramp 4r+c, no stalls
        clear_stats();
        drive_frame(1, 0, 1'b0, 12);
        @(negedge clk) in_valid = 1'b0;
        wait_windows(12, "ramp");
        check_frame(1, 0, 0, "ramp");
        check("ramp_c12", win_q[6], 72'h0B0A09_070605_030201);
        check("ramp_c23", win_q[11], 72'h000000_000B0A_000706);

        // Ramp with random stalls
        clear_stats();
        drive_frame(1, 0, 1'b1, 12);
        @(negedge clk) in_valid = 1'b0;
        wait_windows(12, "stall");
        check_frame(1, 0, 0, "stall");
        check("stall_no_win", 72'(stall_viol), 72'(0));
        check("stall_rdy_low", 72'(rdy_low), 72'(H + W + 1));

        // Mid-frame reset, then fresh flat frame
        drive_frame(1, 100, 1'b0, 6);
        @(negedge clk) begin in_valid = 1'b0; rst = 1'b1; end
        #2 check("midrst_in_ready", 72'(in_ready), 72'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_stats();
        drive_frame(0, 200, 1'b0, 12);
        @(negedge clk) in_valid = 1'b0;
        wait_windows(12, "midrst");
        check_frame(0, 200, 0, "midrst");
        check("midrst_first", win_q[0], 72'hC8C800_C8C800_000000);
        check("midrst_rdy_low", 72'(rdy_low), 72'(H + W + 1));

        // Back-to-back ramp frames
        clear_stats();
        drive_frame(1, 0, 1'b0, 12);
        drive_frame(1, 0, 1'b0, 12);
        @(negedge clk) in_valid = 1'b0;
        wait_windows(24, "b2b");
        check_frame(1, 0, 0, "b2b_f0");
        check_frame(1, 0, 12, "b2b_f1");
        check("b2b_fd_cnt", 72'(fd_cnt), 72'(2));
        check("b2b_acc_at_done", 72'(acc_at_done), 72'(1));

        // Default-size 64x64 frame of 255
        acc = 0;
        cyc = 0;
        while (acc < BW * BH && cyc < 6000) begin
            @(negedge clk);
            b_valid = 1'b1;
            #1;
            if (b_ready) acc++;
            cyc++;
        end
        @(negedge clk) b_valid = 1'b0;
        cyc = 0;
        while (b_cnt < BW * BH && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        check("big_accepted", 72'(acc), 72'(BW * BH));
        check("big_count", 72'(b_cnt), 72'(BW * BH));
        check("big_win_err", 72'(b_err), 72'(0));
        check("big_ct8", 72'(b_c8), 72'(3968));
        check("big_ct3", 72'(b_c3), 72'(62));
        check("big_fd", 72'(b_fd), 72'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
